// File: rtl/noc_packetizer_if.sv
// PE-side payload stream and switch-side flit stream of the noc_packetizer.
interface noc_packetizer_if #(
   parameter int unsigned DataWidth = 32,
   parameter int unsigned DestWidth = 2
);
   logic [DataWidth-1:0] i_pe_data;
   logic                 i_pe_data_valid;
   logic [DestWidth-1:0] i_pe_dest;
   logic                 i_pe_last;
   logic                 o_pe_data_ready;
   logic [DataWidth-1:0] o_noc_data;
   logic                 o_noc_data_valid;
   logic                 i_noc_data_ready;
   logic                 o_trunc;
   logic                 o_busy;

   modport master (
      output i_pe_data, i_pe_data_valid, i_pe_dest, i_pe_last, i_noc_data_ready,
      input  o_pe_data_ready, o_noc_data, o_noc_data_valid, o_trunc, o_busy
   );

   modport slave (
      input  i_pe_data, i_pe_data_valid, i_pe_dest, i_pe_last, i_noc_data_ready,
      output o_pe_data_ready, o_noc_data, o_noc_data_valid, o_trunc, o_busy
   );
endinterface

// File: rtl/noc_packetizer.sv
// Ingress NI: buffers one PE payload burst, then emits a header flit plus payload flits.
// Define PKT_SEQ_EN to carry an 8-bit packet sequence number in header bits [15:8].
module noc_packetizer #(
   parameter int unsigned DataWidth = 32,
   parameter int unsigned DestWidth = 2,
   parameter int unsigned FifoDepth = 8,
   parameter int unsigned SrcId     = 0
) (
   input logic i_clk,
   input logic i_reset,
   noc_packetizer_if.slave bus
);
   localparam int unsigned AddrWidth  = $clog2(FifoDepth);
   localparam int unsigned CountWidth = $clog2(FifoDepth + 1);

   typedef enum logic [1:0] {COLLECT, HEADER, PAYLOAD} state_t;

   state_t                state;
   logic [1:0]            rst_sync;
   logic                  run;
   logic [DataWidth-1:0]  mem [FifoDepth];
   logic [CountWidth-1:0] count;
   logic [CountWidth-1:0] count_inc;
   logic [AddrWidth-1:0]  rd_ptr;
   logic [DestWidth-1:0]  dest_q;
   logic [DestWidth-1:0]  hdr_dest;
   logic [DataWidth-1:0]  header;
   logic [7:0]            seq;
   logic                  pe_accept;
   logic                  noc_hs;
   logic                  closing;

   // Reset asserts asynchronously but the FSM only starts two clocks after release.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) rst_sync <= '0;
      else          rst_sync <= {rst_sync[0], 1'b1};
   end
   assign run = rst_sync[1];

   assign bus.o_pe_data_ready = run && (state == COLLECT);

   always_comb begin
      pe_accept = bus.i_pe_data_valid && bus.o_pe_data_ready;
      noc_hs    = bus.o_noc_data_valid && bus.i_noc_data_ready;
      count_inc = count + 1'b1;
      closing   = pe_accept && (bus.i_pe_last || count_inc == CountWidth'(FifoDepth));
      hdr_dest  = (count == '0) ? bus.i_pe_dest : dest_q;
      header    = '0;
      header[DataWidth-1 -: DestWidth]             = hdr_dest;
      header[DataWidth-1-DestWidth -: DestWidth]   = DestWidth'(SrcId);
      header[7:0]                                  = 8'(count_inc);
      header[15:8]                                 = seq;
   end

   always_ff @(posedge i_clk) begin
      if (pe_accept) mem[count[AddrWidth-1:0]] <= bus.i_pe_data;
   end

   // During PAYLOAD, count holds the number of flits still to send including the one presented.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state                <= COLLECT;
         count                <= '0;
         rd_ptr               <= '0;
         dest_q               <= '0;
         bus.o_noc_data       <= '0;
         bus.o_noc_data_valid <= 1'b0;
         bus.o_trunc          <= 1'b0;
         bus.o_busy           <= 1'b0;
      end else if (run) begin
         bus.o_trunc <= 1'b0;
         unique case (state)
            COLLECT: begin
               if (pe_accept) begin
                  count <= count_inc;
                  if (count == '0) dest_q <= bus.i_pe_dest;
                  if (closing) begin
                     state                <= HEADER;
                     bus.o_noc_data       <= header;
                     bus.o_noc_data_valid <= 1'b1;
                     bus.o_busy           <= 1'b1;
                     bus.o_trunc          <= !bus.i_pe_last;
                  end
               end
            end
            HEADER: begin
               if (noc_hs) begin
                  state          <= PAYLOAD;
                  bus.o_noc_data <= mem[rd_ptr];
                  rd_ptr         <= rd_ptr + 1'b1;
               end
            end
            PAYLOAD: begin
               if (noc_hs) begin
                  if (count == CountWidth'(1)) begin
                     state                <= COLLECT;
                     bus.o_noc_data_valid <= 1'b0;
                     bus.o_busy           <= 1'b0;
                     count                <= '0;
                     rd_ptr               <= '0;
                  end else begin
                     bus.o_noc_data <= mem[rd_ptr];
                     rd_ptr         <= rd_ptr + 1'b1;
                     count          <= count - 1'b1;
                  end
               end
            end
            default: state <= COLLECT;
         endcase
      end
   end

`ifdef PKT_SEQ_EN
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset)                               seq <= '0;
      else if (run && state == HEADER && noc_hs)  seq <= seq + 1'b1;
   end
`else
   assign seq = '0;
`endif
endmodule

// File: tb/tb_noc_packetizer.sv
// Randomised bench for noc_packetizer against a packet-level flit-queue model.
module tb_noc_packetizer;
   localparam int unsigned DW    = 32;
   localparam int unsigned DESTW = 2;
   localparam int unsigned DEPTH = 8;
   localparam int unsigned SRC   = 1;

   typedef struct {
      logic [DW-1:0]    data;
      logic [DESTW-1:0] dest;
      logic             last;
   } word_t;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   noc_packetizer_if #(.DataWidth(DW), .DestWidth(DESTW)) bus ();

   noc_packetizer #(
      .DataWidth(DW),
      .DestWidth(DESTW),
      .FifoDepth(DEPTH),
      .SrcId(SRC)
   ) dut (
      .i_clk(clk),
      .i_reset(rst_n),
      .bus(bus)
   );

   word_t            pe_q[$];
   logic [DW-1:0]    pkt[$];
   logic [DW-1:0]    exp_q[$];
   logic [DESTW-1:0] pkt_dest;
   int unsigned      n_hdr;
   bit               trunc_next;
   bit               chk_en;
   int               ready_mode;
   int unsigned      valid_pct;
   int               n_cmp = 0;
   int               n_mis = 0;

   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] make_header(input logic [DESTW-1:0] d, input int unsigned len,
                                                 input int unsigned sq);
      logic [DW-1:0] h;
      h = DW'(d) << (DW - DESTW);
      h = h | (DW'(SRC) << (DW - 2 * DESTW));
      h = h | DW'(len % 256);
`ifdef PKT_SEQ_EN
      h = h | DW'((sq % 256) << 8);
`else
      if (sq > 32'hFFFF_FFFE) h = '0;
`endif
      return h;
   endfunction

   task automatic push_word(input logic [DW-1:0] d, input logic [DESTW-1:0] dst, input logic l);
      word_t w;
      w.data = d;
      w.dest = dst;
      w.last = l;
      pe_q.push_back(w);
   endtask

   task automatic drive();
      if (pe_q.size() != 0 && $urandom_range(0, 99) < valid_pct) begin
         bus.i_pe_data_valid = 1'b1;
         bus.i_pe_data       = pe_q[0].data;
         bus.i_pe_dest       = pe_q[0].dest;
         bus.i_pe_last       = pe_q[0].last;
      end else begin
         bus.i_pe_data_valid = 1'b0;
         bus.i_pe_data       = DW'($urandom);
         bus.i_pe_dest       = DESTW'($urandom);
         bus.i_pe_last       = 1'($urandom);
      end
      case (ready_mode)
         0:       bus.i_noc_data_ready = 1'b1;
         1:       bus.i_noc_data_ready = !bus.i_noc_data_ready;
         default: bus.i_noc_data_ready = 1'($urandom_range(0, 1));
      endcase
   endtask

   // One clock: check outputs against the model, then advance the model by the handshakes.
   task automatic step();
      bit pe_acc;
      bit noc_hs;
      @(negedge clk);
      if (chk_en) begin
         check("trunc", DW'(bus.o_trunc), DW'(trunc_next));
         check("pe_ready", DW'(bus.o_pe_data_ready), DW'(exp_q.size() == 0));
         check("noc_valid", DW'(bus.o_noc_data_valid), DW'(exp_q.size() != 0));
         check("busy", DW'(bus.o_busy), DW'(exp_q.size() != 0));
         if (exp_q.size() != 0) check("noc_data", bus.o_noc_data, exp_q[0]);
      end
      trunc_next = 1'b0;
      pe_acc = bus.i_pe_data_valid && bus.o_pe_data_ready;
      noc_hs = bus.o_noc_data_valid && bus.i_noc_data_ready;
      if (noc_hs && exp_q.size() != 0) void'(exp_q.pop_front());
      if (pe_acc) begin
         if (pkt.size() == 0) pkt_dest = bus.i_pe_dest;
         pkt.push_back(bus.i_pe_data);
         if (bus.i_pe_last || pkt.size() == int'(DEPTH)) begin
            exp_q.push_back(make_header(pkt_dest, pkt.size(), n_hdr));
            n_hdr++;
            foreach (pkt[i]) exp_q.push_back(pkt[i]);
            trunc_next = !bus.i_pe_last;
            pkt.delete();
         end
      end
      @(posedge clk);
      #1;
      if (pe_acc && pe_q.size() != 0) void'(pe_q.pop_front());
      drive();
   endtask

   task automatic run_idle(input string tag, input int budget);
      int n;
      n = 0;
      while ((pe_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
         step();
         n++;
      end
      check(tag, DW'(pe_q.size() + exp_q.size()), '0);
      repeat (2) step();
   endtask

   task automatic do_reset();
      int n;
      rst_n = 1'b0;
      bus.i_pe_data_valid = 1'b0;
      #1;
      check("rst_noc_data", bus.o_noc_data, '0);
      check("rst_noc_valid", DW'(bus.o_noc_data_valid), '0);
      check("rst_trunc", DW'(bus.o_trunc), '0);
      check("rst_busy", DW'(bus.o_busy), '0);
      check("rst_pe_ready", DW'(bus.o_pe_data_ready), '0);
      pe_q.delete();
      pkt.delete();
      exp_q.delete();
      n_hdr = 0;
      trunc_next = 1'b0;
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      n = 0;
      @(negedge clk);
      while (!bus.o_pe_data_ready && n < 10) begin
         @(negedge clk);
         n++;
      end
      check("ready_after_reset", DW'(bus.o_pe_data_ready), DW'(1));
      @(posedge clk);
      #1;
      drive();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.i_pe_data        = '0;
      bus.i_pe_data_valid  = 1'b0;
      bus.i_pe_dest        = '0;
      bus.i_pe_last        = 1'b0;
      bus.i_noc_data_ready = 1'b1;
      ready_mode = 0;
      valid_pct  = 100;
      chk_en     = 1'b0;
      do_reset();
      chk_en = 1'b1;

      // Single-word packet.
      push_word(32'hA5A5_A5A5, 2'd3, 1'b1);
      run_idle("drain_single", 50);

      // Four words with toggling switch ready.
      ready_mode = 1;
      for (int i = 0; i < 4; i++) push_word(DW'($urandom), 2'd2, i == 3);
      run_idle("drain_toggle", 100);

      // Ten words without last: truncated at DEPTH, remainder forms a second packet.
      ready_mode = 0;
      for (int i = 0; i < 10; i++) push_word(32'h1000_0000 + DW'(i), 2'd1, 1'b0);
      for (int i = 0; i < 60 && pe_q.size() != 0; i++) step();
      push_word(32'h1000_00FF, 2'd1, 1'b1);
      run_idle("drain_trunc", 100);

      // Reset after three words collected; nothing may be emitted.
      for (int i = 0; i < 3; i++) push_word(32'hDEAD_0000 + DW'(i), 2'd0, 1'b0);
      for (int i = 0; i < 20 && pe_q.size() != 0; i++) step();
      repeat (2) step();
      chk_en = 1'b0;
      do_reset();
      chk_en = 1'b1;
      repeat (3) step();
      push_word(32'h0BAD_F00D, 2'd2, 1'b1);
      run_idle("drain_after_reset", 50);

      // 257 back-to-back single-word packets exercise the sequence field wrap.
      for (int i = 0; i < 257; i++) push_word(DW'($urandom), DESTW'($urandom), 1'b1);
      run_idle("drain_seq", 3000);

      // Random traffic with PE gaps and switch backpressure.
      ready_mode = 2;
      valid_pct  = 70;
      for (int i = 0; i < 400; i++)
         push_word(DW'($urandom), DESTW'($urandom), $urandom_range(0, 3) == 0);
      push_word(DW'($urandom), DESTW'($urandom), 1'b1);
      run_idle("drain_random", 8000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule
